// File: rtl/lane_queue_if.sv
// lane_queue_if: handshake bundle between a lane_queue and its producer/consumer.
//
// Parameters must match the lane_queue instance they connect to.
//   flush     : redirect, empties the queue at the next edge
//   in_valid  : per-lane enqueue request, prefix mask
//   in_data   : enqueue payload, lane i at [i*WIDTH +: WIDTH]
//   in_ready  : room for a full group of LANES entries
//   out_valid : per-lane head-entry occupancy
//   out_data  : payloads of entries head+0 .. head+LANES-1
//   deq_num   : number of head entries the consumer retires this cycle
//   count     : current occupancy
//
// master = producer/consumer side, slave = the queue itself.
interface lane_queue_if #(
    parameter int WIDTH = 64,
    parameter int LANES = 2,
    parameter int DEPTH = 8
);
    localparam int DW = $clog2(LANES + 1);
    localparam int CW = $clog2(DEPTH + 1);

    logic                   flush;
    logic [LANES-1:0]       in_valid;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   in_ready;
    logic [LANES-1:0]       out_valid;
    logic [LANES*WIDTH-1:0] out_data;
    logic [DW-1:0]          deq_num;
    logic [CW-1:0]          count;

    modport master (
        output flush, in_valid, in_data, deq_num,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, deq_num,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/lane_queue.sv
// lane_queue: multi-lane decoupling queue between two pipeline stages.
//
// Accepts up to LANES entries per cycle, stores up to DEPTH entries and
// presents the oldest LANES entries in program order. The consumer retires
// 0..LANES entries per cycle through deq_num (clamped to the occupancy).
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-high reset
//   q     : lane_queue_if.slave (flush, in_*, out_*, deq_num, count)
//
// Optional build macro LANE_QUEUE_BYPASS_EN: when the queue is empty the
// input lanes are forwarded combinationally to the outputs and the consumer
// may retire them in the same cycle; only the unconsumed remainder is stored.
// Without the macro there is a strict one-cycle latency and no in->out path.
module lane_queue #(
    parameter int WIDTH = 64,
    parameter int LANES = 2,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    lane_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int DW = $clog2(LANES + 1);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    head_reg, head_next;
    logic [PW-1:0]    tail_reg, tail_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] mem [DEPTH];

    logic          in_ready;
    logic          enq_ok;
    logic [DW-1:0] n_in;      // lanes accepted this cycle
    logic [DW-1:0] n_deq;     // entries retired from storage
    logic [DW-1:0] n_byp;     // input lanes consumed without being stored
    logic [DW-1:0] n_wr;      // lanes actually written into storage

    logic             wr_en    [LANES];
    logic [PW-1:0]    wr_idx   [LANES];
    logic             lane_vld [LANES];
    logic [WIDTH-1:0] lane_dat [LANES];

    // Readiness looks only at registered occupancy, so space freed by a
    // same-cycle dequeue is not offered until the next cycle.
    assign in_ready = (count_reg <= CW'(DEPTH - LANES));
    assign enq_ok   = in_ready && !q.flush;

    always_comb begin
        n_in = '0;
        for (int i = 0; i < LANES; i++) begin
            n_in = n_in + DW'(q.in_valid[i]);
        end
        if (!enq_ok) begin
            n_in = '0;
        end
    end

    // Over-asking is clamped to what is actually stored.
    always_comb begin
        if (CW'(q.deq_num) > count_reg) begin
            n_deq = count_reg[DW-1:0];
        end else begin
            n_deq = q.deq_num;
        end
    end

`ifdef LANE_QUEUE_BYPASS_EN
    logic bypass_active;
    // Reset is included so the outputs stay quiet while reset is held.
    assign bypass_active = (count_reg == '0) && !q.flush && !reset;

    always_comb begin
        n_byp = '0;
        if (bypass_active) begin
            n_byp = (q.deq_num < n_in) ? q.deq_num : n_in;
        end
    end
`else
    assign n_byp = '0;
`endif

    assign n_wr = n_in - n_byp;

    always_comb begin
        head_next  = head_reg + PW'(n_deq);
        tail_next  = tail_reg + PW'(n_wr);
        count_next = count_reg + CW'(n_wr) - CW'(n_deq);
        if (q.flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [PW-1:0] rd_idx;
            logic          stored_vld;

            // Bypassed lanes are skipped, so lane n_byp lands exactly at tail.
            assign wr_en[gi]  = enq_ok && q.in_valid[gi] && (DW'(gi) >= n_byp);
            assign wr_idx[gi] = tail_reg + PW'(gi) - PW'(n_byp);

            assign rd_idx     = head_reg + PW'(gi);
            assign stored_vld = (count_reg > CW'(gi));

`ifdef LANE_QUEUE_BYPASS_EN
            assign lane_vld[gi] = bypass_active ? q.in_valid[gi] : stored_vld;
            assign lane_dat[gi] = !lane_vld[gi] ? '0 :
                                  bypass_active ? q.in_data[gi*WIDTH +: WIDTH] :
                                                  mem[rd_idx];
`else
            assign lane_vld[gi] = stored_vld;
            // Invalid lanes are zeroed so the outputs read 0 out of reset.
            assign lane_dat[gi] = stored_vld ? mem[rd_idx] : '0;
`endif
        end
    endgenerate

    // Storage has no reset; occupancy alone decides what is meaningful.
    // Write indices of a group are distinct because LANES <= DEPTH.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) begin
                mem[wr_idx[i]] <= q.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        q.out_valid = '0;
        q.out_data  = '0;
        for (int i = 0; i < LANES; i++) begin
            q.out_valid[i]                = lane_vld[i];
            q.out_data[i*WIDTH +: WIDTH]  = lane_dat[i];
        end
    end

    assign q.in_ready = in_ready;
    assign q.count    = count_reg;

endmodule

// File: tb/tb_lane_queue.sv
module tb_lane_queue;
    localparam int WIDTH = 64;
    localparam int LANES = 2;
    localparam int DEPTH = 8;
`ifdef LANE_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lane_queue_if #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) qif ();

    lane_queue #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (qif.slave)
    );

    int tests  = 0;
    int failed = 0;

    // Reference: contents of the queue, oldest first.
    logic [WIDTH-1:0] model_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        qif.flush    = 1'b0;
        qif.in_valid = '0;
        qif.in_data  = '0;
        qif.deq_num  = '0;
    endtask

    // Registered state against the model (inputs idle).
    task automatic check_state(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ".count"}, 128'(qif.count), 128'(sz));
        check({tag, ".in_ready"}, 128'(qif.in_ready), 128'(sz <= DEPTH - LANES));
        for (int i = 0; i < LANES; i++) begin
            check($sformatf("%s.out_valid%0d", tag, i), 128'(qif.out_valid[i]), 128'(sz > i));
            if (sz > i)
                check($sformatf("%s.out_data%0d", tag, i),
                      128'(qif.out_data[i*WIDTH +: WIDTH]), 128'(model_q[i]));
        end
    endtask

    // One clock of traffic: apply, check combinational outputs, step the
    // model, clock, then compare the registered result.
    task automatic cycle(input logic [1:0] v, input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                         input logic [1:0] deq, input logic fl, input string tag);
        int sz, nin, nout, take;
        bit ready;
        logic [WIDTH-1:0] lane_d [2];
        lane_d[0] = d0;
        lane_d[1] = d1;
        qif.in_valid = v;
        qif.in_data  = {d1, d0};
        qif.deq_num  = deq;
        qif.flush    = fl;
        #1;
        sz    = model_q.size();
        ready = (sz <= DEPTH - LANES);
        nin   = int'(v[0]) + int'(v[1]);
        if (BYPASS && sz == 0 && !fl) begin
            check({tag, ".pre_valid"}, 128'(qif.out_valid), 128'(v));
            for (int i = 0; i < LANES; i++)
                if (v[i])
                    check($sformatf("%s.pre_data%0d", tag, i),
                          128'(qif.out_data[i*WIDTH +: WIDTH]), 128'(lane_d[i]));
        end else begin
            check({tag, ".pre_valid"}, 128'(qif.out_valid),
                  128'((sz >= 2) ? 2'b11 : (sz == 1) ? 2'b01 : 2'b00));
        end
        if (fl) begin
            model_q.delete();
        end else if (BYPASS && sz == 0) begin
            take = (int'(deq) < nin) ? int'(deq) : nin;
            for (int i = take; i < nin; i++) model_q.push_back(lane_d[i]);
        end else begin
            nout = (int'(deq) < sz) ? int'(deq) : sz;
            for (int i = 0; i < nout; i++) void'(model_q.pop_front());
            if (ready)
                for (int i = 0; i < nin; i++) model_q.push_back(lane_d[i]);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check_state(tag);
        $display("[TB] %s v=%b deq=%0d flush=%0d -> count=%0d", tag, v, deq, fl, qif.count);
    endtask

    initial begin
        logic [1:0] rv;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset.count", 128'(qif.count), 128'(0));
        check("reset.in_ready", 128'(qif.in_ready), 128'(1));
        check("reset.out_valid", 128'(qif.out_valid), 128'(0));
        check("reset.out_data", 128'(qif.out_data), 128'(0));
        reset = 1'b0;
        #1;

        // Order check
        cycle(2'b11, 64'hA, 64'hB, 2'd0, 1'b0, "enq_ab");
        check("enq_ab.lane0", 128'(qif.out_data[63:0]), 128'(64'hA));
        check("enq_ab.lane1", 128'(qif.out_data[127:64]), 128'(64'hB));
        cycle(2'b00, 64'h0, 64'h0, 2'd1, 1'b0, "deq1");
        check("deq1.lane0", 128'(qif.out_data[63:0]), 128'(64'hB));
        cycle(2'b00, 64'h0, 64'h0, 2'd2, 1'b0, "deq_clamp");
        check("deq_clamp.count", 128'(qif.count), 128'(0));

        // Bypass (or plain latency) on an empty queue
        cycle(2'b11, 64'hC, 64'hD, 2'd1, 1'b0, "bypass");
        check("bypass.count", 128'(qif.count), 128'(BYPASS ? 1 : 2));
        check("bypass.lane0", 128'(qif.out_data[63:0]), 128'(BYPASS ? 64'hD : 64'hC));
        cycle(2'b00, 64'h0, 64'h0, 2'd0, 1'b1, "flush0");

        // Fill to full
        for (int k = 0; k < 4; k++)
            cycle(2'b11, 64'(16 + 2*k), 64'(17 + 2*k), 2'd0, 1'b0, $sformatf("fill%0d", k));
        check("full.count", 128'(qif.count), 128'(8));
        check("full.in_ready", 128'(qif.in_ready), 128'(0));
        cycle(2'b11, 64'hEE, 64'hEF, 2'd0, 1'b0, "full_enq");
        check("full_enq.count", 128'(qif.count), 128'(8));

        // Partial-free edge
        cycle(2'b00, 64'h0, 64'h0, 2'd1, 1'b0, "to7");
        check("c7.in_ready", 128'(qif.in_ready), 128'(0));
        cycle(2'b11, 64'hF0, 64'hF1, 2'd2, 1'b0, "c7_deq2");
        check("c5.count", 128'(qif.count), 128'(5));
        check("c5.in_ready", 128'(qif.in_ready), 128'(1));

        // Flush priority
        cycle(2'b11, 64'hAA, 64'hBB, 2'd2, 1'b1, "flush_pri");
        check("flush_pri.count", 128'(qif.count), 128'(0));
        check("flush_pri.tail", 128'(dut.tail_reg), 128'(0));
        cycle(2'b11, 64'd0, 64'd1, 2'd0, 1'b0, "post_flush");

        // Wrap-around streaming
        for (int k = 1; k <= 20; k++)
            cycle(2'b11, 64'(2*k), 64'(2*k + 1), 2'd2, 1'b0, $sformatf("wrap%0d", k));
        check("wrap.count", 128'(qif.count), 128'(2));

        // Reset mid-operation
        cycle(2'b11, 64'h55, 64'h66, 2'd0, 1'b0, "pre_rst");
        reset = 1'b1;
        #1;
        check("midrst.count", 128'(qif.count), 128'(0));
        check("midrst.out_valid", 128'(qif.out_valid), 128'(0));
        model_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        cycle(2'b01, 64'h77, 64'h0, 2'd0, 1'b0, "post_rst");
        check("post_rst.tail", 128'(dut.tail_reg), 128'(1));

        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 2))
                0:       rv = 2'b00;
                1:       rv = 2'b01;
                default: rv = 2'b11;
            endcase
            cycle(rv, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 2)),
                  ($urandom_range(0, 19) == 0), $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/lane_queue.md
Name: lane_queue

Overview:
- Parametrised multi-lane decoupling queue that replaces a fixed single-entry stage register (e.g. the decode→renaming boundary).
- Accepts up to LANES instructions per cycle, buffers up to DEPTH entries, and presents the oldest LANES entries in program order.
- The consumer retires 0..LANES entries per cycle.
- A single flush input empties the queue on branch/exception redirect.

Parameters:
- WIDTH, 64, payload bits per lane (one decoded/renamed instruction record).
- LANES, 2, enqueue and dequeue lanes per cycle (MACHINE_WIDTH). Must be ≥1.
- DEPTH, 8, entry count. Power of two, DEPTH ≥ 2*LANES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous flush; empties the queue at the next edge.
- in_valid  in  LANES  per-lane enqueue request. Must be a prefix mask (lane i valid ⇒ lanes 0..i-1 valid).
- in_data  in  LANES*WIDTH  enqueue payload. Lane i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  1  high when free entries ≥ LANES.
- out_valid  out  LANES  out_valid[i] high when entry head+i is occupied.
- out_data  out  LANES*WIDTH  payload of entries head+0 .. head+LANES-1.
- deq_num  in  clog2(LANES+1)  number of head entries consumed this cycle.
- count  out  clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async, takes effect immediately):
  - head=0, tail=0, count=0.
  - in_ready=1, out_valid=0, out_data=0. Memory contents are don't-care.
- Enqueue:
  - Applies when in_ready=1 and flush=0. n_in = popcount(in_valid).
  - Lane i is written to mem[(tail+i) mod DEPTH]; tail advances by n_in.
  - in_ready is all-or-nothing: when in_ready=0, in_valid is ignored and nothing is written.
  - The producer holds its data until in_ready=1.
- Dequeue:
  - n_out = min(deq_num, count). deq_num > count is clamped, not an error.
  - head advances by n_out, mod DEPTH.
- Occupancy and readiness:
  - count_next = count + n_in − n_out.
  - in_ready derives from the current count only (registered occupancy). Same-cycle dequeue does not raise in_ready.
  - Entries freed this cycle become visible as free space next cycle.
- Latency:
  - Without the optional feature, an entry enqueued at edge t appears on out_valid/out_data after edge t (one-cycle latency).
  - No combinational path from in_* to out_*.
- Output mapping:
  - out_valid[i] = (count > i).
  - out_data lane i = mem[(head+i) mod DEPTH], combinational read of registered storage.
  - Lanes with out_valid=0 carry don't-care data.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full/empty is determined by count, never by pointer equality.
- Boundaries:
  - Full (count=DEPTH): in_ready=0; dequeue proceeds normally.
  - Empty: out_valid=0; deq_num is ignored.
  - count=DEPTH−LANES+1: in_ready=0, even if fewer than LANES lanes are valid.
- Flush:
  - At the next edge, head=tail=count=0 regardless of same-cycle in_valid or deq_num. Enqueue and dequeue in that cycle are discarded.
  - flush takes priority over everything except reset.
- Reset mid-operation: all entries are lost immediately. The first enqueue after reset deasserts writes to index 0.

Optional Feature:
- Macro: LANE_QUEUE_BYPASS_EN.
- When defined:
  - If count=0 and flush=0, out_valid/out_data mirror in_valid/in_data combinationally (zero latency).
  - n_out = min(deq_num, n_in) entries are consumed directly from the input.
  - The remaining n_in−n_out lanes are written starting at tail, so lane n_out lands at index tail.
  - in_ready rule is unchanged.
- When not defined: strict one-cycle latency; no in→out combinational path.

Test Plan:
- Enqueue/order check:
  - Reset, then enqueue in_valid=2'b11 with data {0xB,0xA}, deq_num=0 → next cycle count=2, out_valid=2'b11, lane0=0xA, lane1=0xB.
  - Then deq_num=1 → count=1, lane0=0xB.
- Fill to full: DEPTH=8, LANES=2, four double-enqueues with no dequeue → count=8, in_ready=0. A fifth enqueue attempt writes nothing; count stays 8.
- Wrap-around with simultaneous traffic:
  - Stream enqueue 2/cycle and deq_num=2 for 20 cycles with an incrementing payload 0,1,2…
  - Expected: outputs are in strict order, count stays 2, pointers wrap at 8.
- Partial-free edge: count=7 with deq_num=2 in the same cycle → in_ready=0 that cycle; next cycle count=5, in_ready=1.
- Flush priority: count=5, flush=1 with in_valid=2'b11 and deq_num=2 → next cycle count=0, out_valid=0. A subsequent enqueue lands at index 0.
- Bypass (LANE_QUEUE_BYPASS_EN): on an empty queue, apply in_valid=2'b11 {0xD,0xC} and deq_num=1 in the same cycle.
  - Same cycle: out lane0=0xC.
  - Next cycle: count=1, lane0=0xD.
  - Without the macro, the same stimulus gives out_valid=0 that cycle and count=2 after.
